// File: rtl/aes_loader_pkg.sv
// Shared definitions for the AES input loader.
//   state_e       : loader FSM states (LOAD, RUN, DRAIN)
//   WORD_W        : width of one stream word
//   BLK_W         : width of one AES block / key
//   WORDS_PER_BLK : stream words per block
//   CNT_W         : width of a 0..WORDS_PER_BLK word counter
package aes_loader_pkg;
  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = BLK_W / WORD_W;
  localparam int CNT_W         = $clog2(WORDS_PER_BLK + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/aes_word_packer.sv
// Shift-in packer: assembles WORDS_PER_BLK words into one block, first word
// ending up in the most significant position.
//   clk      : clock
//   rst      : synchronous active-high reset (clears block and counter)
//   shift_en : shift word in this cycle
//   clr      : clear the word counter (block contents are kept)
//   word     : incoming word
//   blk      : assembled block
//   cnt      : words shifted since last clear, saturating at WORDS_PER_BLK
module aes_word_packer
  import aes_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [WORD_W-1:0] word,
  output logic [BLK_W-1:0]  blk,
  output logic [CNT_W-1:0]  cnt
);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    blk_d = blk_q;
    cnt_d = cnt_q;
    if (shift_en) begin
      blk_d = {blk_q[BLK_W-WORD_W-1:0], word};
      if (cnt_q != CNT_W'(WORDS_PER_BLK)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // clr wins over the increment so a final word can shift in and wrap at once
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  assign blk = blk_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/aes_input_loader.sv
// Upstream feeder for the AES core. Collects 32-bit words from a valid/ready
// stream into a 128-bit key and data block, launches the core and holds its
// inputs stable until completion (or timeout), then idles GAP_CYC cycles.
//   AES_clk, AES_rst       : clock, synchronous active-high reset
//   in_valid/in_ready      : word handshake; in_is_key selects key or data
//   in_word                : word payload
//   AES_data_out_valid     : core completion flag (only honoured in RUN)
//   AES_en                 : core enable, high for the whole RUN state
//   AES_data_in/AES_key_in : block and key presented to the core
//   key_loaded             : a complete key is held
//   busy                   : loader not in LOAD
//   blk_done               : one-cycle pulse after normal completion
//   timeout_err            : sticky abort flag, cleared by the next accepted word
module aes_input_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_is_key,
  input  logic              AES_data_out_valid,
  output logic              AES_en,
  output logic [BLK_W-1:0]  AES_data_in,
  output logic [BLK_W-1:0]  AES_key_in,
  output logic              key_loaded,
  output logic              busy,
  output logic              blk_done,
  output logic              timeout_err
);

  localparam int RUN_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             key_loaded_q, key_loaded_d;
  logic             blk_done_q, blk_done_d;
  logic             timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0] key_cnt, data_cnt;
  logic             data_full;
  logic             accept, key_accept, data_accept;
  logic             key_last, run_exit;

  assign data_full   = (data_cnt == CNT_W'(WORDS_PER_BLK));
  // Only data words stall once the data block is full, so a missing key can
  // still be loaded behind it.
  assign in_ready    = (state_q == LOAD) && !(data_full && !in_is_key);
  assign accept      = in_valid && in_ready;
  assign key_accept  = accept && in_is_key;
  assign data_accept = accept && !in_is_key;
  assign key_last    = key_accept && (key_cnt == CNT_W'(WORDS_PER_BLK - 1));
  assign run_exit    = (state_q == RUN) && (state_d != RUN);

  aes_word_packer u_key_packer (
    .clk      (AES_clk),
    .rst      (AES_rst),
    .shift_en (key_accept),
    .clr      (key_last),
    .word     (in_word),
    .blk      (AES_key_in),
    .cnt      (key_cnt)
  );

  aes_word_packer u_data_packer (
    .clk      (AES_clk),
    .rst      (AES_rst),
    .shift_en (data_accept),
    .clr      (run_exit),
    .word     (in_word),
    .blk      (AES_data_in),
    .cnt      (data_cnt)
  );

  // Key bookkeeping: starting a new key invalidates the old one until the
  // fourth word arrives.
  always_comb begin
    key_loaded_d = key_loaded_q;
    if (key_accept && (key_cnt == '0)) begin
      key_loaded_d = 1'b0;
    end
    if (key_last) begin
      key_loaded_d = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    blk_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    // Words are only accepted in LOAD, so this never collides with the set below.
    if (accept) begin
      timeout_err_d = 1'b0;
    end
    case (state_q)
      LOAD: begin
        run_cnt_d = '0;
        gap_cnt_d = '0;
        // Launch is decided from registered counters, so the core sees
        // AES_en one cycle after the completing word.
        if (data_full && key_loaded_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RUN_W'(1);
        if (AES_data_out_valid) begin
          state_d    = DRAIN;
          blk_done_d = 1'b1;
        end else if (run_cnt_q == RUN_W'(TIMEOUT_CYC - 1)) begin
          state_d       = DRAIN;
          timeout_err_d = 1'b1;
        end
      end
      DRAIN: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q       <= LOAD;
      run_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      key_loaded_q  <= 1'b0;
      blk_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      key_loaded_q  <= key_loaded_d;
      blk_done_q    <= blk_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign AES_en      = (state_q == RUN);
  assign busy        = (state_q != LOAD);
  assign key_loaded  = key_loaded_q;
  assign blk_done    = blk_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aes_input_loader.sv
module tb_aes_input_loader;
  localparam int TIMEOUT_CYC = 64;
  localparam int GAP_CYC     = 2;
  localparam int WAIT_MAX    = 200;

  logic         AES_clk = 1'b0;
  logic         AES_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_is_key = 1'b0;
  logic [31:0]  in_word = '0;
  logic         AES_data_out_valid = 1'b0;
  logic         in_ready, AES_en, key_loaded, busy, blk_done, timeout_err;
  logic [127:0] AES_data_in, AES_key_in;

  int checks = 0;
  int errors = 0;

  // Reference model: words are remembered by position, block = word0..word3 MSB first.
  logic [31:0] m_key [4];
  logic [31:0] m_data [4];
  int          m_kidx = 0;
  int          m_didx = 0;
  logic        m_key_ok = 1'b0;
  logic        m_te = 1'b0;
  int          blk_no = 0;

  always #5 AES_clk = ~AES_clk;

  aes_input_loader #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_word            (in_word),
    .in_is_key          (in_is_key),
    .AES_data_out_valid (AES_data_out_valid),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .key_loaded         (key_loaded),
    .busy               (busy),
    .blk_done           (blk_done),
    .timeout_err        (timeout_err)
  );

  function automatic logic [127:0] exp_key();
    return {m_key[0], m_key[1], m_key[2], m_key[3]};
  endfunction

  function automatic logic [127:0] exp_data();
    return {m_data[0], m_data[1], m_data[2], m_data[3]};
  endfunction

  task automatic step();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i]  = '0;
      m_data[i] = '0;
    end
    m_kidx = 0; m_didx = 0; m_key_ok = 1'b0; m_te = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_en"}, AES_en, 1'b0);
    chk_w({tag, "_data"}, AES_data_in, '0);
    chk_w({tag, "_key"}, AES_key_in, '0);
    chk_b({tag, "_key_loaded"}, key_loaded, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_blk_done"}, blk_done, 1'b0);
    chk_b({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  // Offer one word and wait (bounded) until it is accepted on an edge.
  task automatic send_word(input logic [31:0] w, input logic k);
    int n = 0;
    in_valid = 1'b1; in_word = w; in_is_key = k;
    #1;
    while (!in_ready && n < WAIT_MAX) begin
      step();
      n++;
    end
    chk_b("accept_in_time", (n < WAIT_MAX), 1'b1);
    step();
    in_valid = 1'b0;
    if (k) begin
      if (m_kidx == 0) m_key_ok = 1'b0;
      m_key[m_kidx] = w;
      if (m_kidx == 3) m_key_ok = 1'b1;
      m_kidx = (m_kidx + 1) % 4;
    end else begin
      m_data[m_didx] = w;
      m_didx++;
    end
    m_te = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] a, b, c, d);
    send_word(a, 1'b1);
    chk_b("key_loaded_cleared", key_loaded, 1'b0);
    send_word(b, 1'b1);
    send_word(c, 1'b1);
    send_word(d, 1'b1);
  endtask

  task automatic send_data(input logic [31:0] a, b, c, d);
    send_word(a, 1'b0);
    send_word(b, 1'b0);
    send_word(c, 1'b0);
    send_word(d, 1'b0);
  endtask

  // Called right after the edge that accepted the completing word.
  // resp = RUN cycle index at which the core model raises valid (<0: never).
  task automatic run_block(input int resp);
    int  n = 0;
    bit  exp_done;
    int  exp_n;
    exp_done = (resp >= 0) && (resp < TIMEOUT_CYC);
    exp_n    = exp_done ? resp + 1 : TIMEOUT_CYC;
    chk_b("pre_launch_en", AES_en, 1'b0);
    step();
    chk_b("launch_en", AES_en, 1'b1);
    chk_b("launch_busy", busy, 1'b1);
    chk_b("run_ready", in_ready, 1'b0);
    chk_b("run_key_loaded", key_loaded, 1'b1);
    chk_w("key_in", AES_key_in, exp_key());
    chk_w("data_in", AES_data_in, exp_data());
    while (AES_en && n < WAIT_MAX) begin
      AES_data_out_valid = (n == resp);
      step();
      n++;
    end
    AES_data_out_valid = 1'b0;
    chk_i("en_cycles", n, exp_n);
    if (!exp_done) m_te = 1'b1;
    chk_b("blk_done", blk_done, exp_done);
    chk_b("timeout_err", timeout_err, m_te);
    chk_b("drain_busy", busy, 1'b1);
    chk_b("drain_ready", in_ready, 1'b0);
    chk_w("data_hold", AES_data_in, exp_data());
    chk_w("key_hold", AES_key_in, exp_key());
    for (int g = 1; g < GAP_CYC; g++) begin
      step();
      chk_b("gap_ready", in_ready, 1'b0);
      chk_b("done_single_pulse", blk_done, 1'b0);
    end
    step();
    chk_b("rearm_ready", in_ready, 1'b1);
    chk_b("rearm_busy", busy, 1'b0);
    chk_b("rearm_done_low", blk_done, 1'b0);
    chk_b("rearm_key_loaded", key_loaded, m_key_ok);
    m_didx = 0;
    $display("block %0d resp=%0d en_cycles=%0d key=%h data=%h", blk_no, resp, n, exp_key(), exp_data());
    blk_no++;
  endtask

  initial begin
    int resp;
    model_reset();
    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    chk_b("reset_ready", in_ready, 1'b1);
    AES_rst = 1'b0;
    step();

    // Directed first block, core answers at RUN cycle 10
    send_key(32'haa2bdb40, 32'hbff6a5e8, 32'hcaa9ba3e, 32'hbc1e2acc);
    chk_b("key_loaded_set", key_loaded, 1'b1);
    send_data(32'h00000024, 32'h0, 32'h0, 32'h0);
    chk_w("vec_key", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chk_w("vec_data", AES_data_in, 128'h00000024_00000000_00000000_00000000);
    run_block(10);

    // Second block reuses the retained key
    send_data(32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681);
    chk_w("vec_data2", AES_data_in, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
    run_block(int'($urandom_range(0, 20)));

    // Core never responds
    send_data($urandom, $urandom, $urandom, $urandom);
    run_block(-1);
    chk_b("timeout_sticky", timeout_err, 1'b1);
    send_word($urandom, 1'b0);
    chk_b("timeout_cleared", timeout_err, 1'b0);

    // Valid on the timeout cycle: completion wins
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    run_block(TIMEOUT_CYC - 1);

    // Reset in the middle of RUN
    send_data($urandom, $urandom, $urandom, $urandom);
    step();
    chk_b("midrun_en", AES_en, 1'b1);
    for (int i = 0; i < 5; i++) step();
    AES_rst = 1'b1;
    step();
    model_reset();
    check_reset_outputs("midrun_reset");
    chk_b("midrun_ready", in_ready, 1'b1);
    AES_rst = 1'b0;
    step();

    // Data first, key afterwards
    send_data($urandom, $urandom, $urandom, $urandom);
    in_valid = 1'b1; in_is_key = 1'b0; in_word = $urandom;
    #1;
    chk_b("full_data_stall", in_ready, 1'b0);
    step();
    chk_b("full_data_stall2", in_ready, 1'b0);
    chk_b("no_launch_without_key", AES_en, 1'b0);
    in_is_key = 1'b1;
    #1;
    chk_b("key_ready_when_full", in_ready, 1'b1);
    in_valid = 1'b0;
    send_key($urandom, $urandom, $urandom, $urandom);
    run_block(int'($urandom_range(0, 30)));

    // Randomised blocks, occasionally with a fresh key
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_key($urandom, $urandom, $urandom, $urandom);
      end
      send_data($urandom, $urandom, $urandom, $urandom);
      resp = int'($urandom_range(0, TIMEOUT_CYC + 6));
      run_block(resp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
